// File: rtl/chacha_core_seq.sv
// chacha_core_seq: iterative ChaCha keystream generator.
// One full round (four parallel quarter-rounds) per clock. A job is a run of
// consecutive blocks that share key and nonce. The 32-bit block counter
// advances automatically between blocks. Each 512-bit result is offered on a
// valid/ready handshake and held until the consumer takes it.
module chacha_core_seq #(
    parameter int ROUNDS = 20,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [255:0]     key,
    input  logic [95:0]      nonce,
    input  logic [31:0]      counter_init,
    input  logic [CNT_W-1:0] num_blocks,
    output logic [511:0]     ks_data,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic             busy,
    output logic             done,
    output logic             ctr_wrap
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [31:0] SIGMA0 = 32'h61707865;
    localparam logic [31:0] SIGMA1 = 32'h3320646e;
    localparam logic [31:0] SIGMA2 = 32'h79622d32;
    localparam logic [31:0] SIGMA3 = 32'h6b206574;

    // Index of the last round. The round counter holds the number of rounds
    // already applied, so it reaches this value while the last round is
    // being computed.
    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

    // Only the standard reduced-round variants are supported. Odd counts would
    // end on a half double-round.
    if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
        $error("chacha_core_seq: ROUNDS must be 8, 12 or 20");
    end

    // Quarter-round on four words; result packed as {d, c, b, a}
    function automatic logic [127:0] quarter(
        input logic [31:0] a_in,
        input logic [31:0] b_in,
        input logic [31:0] c_in,
        input logic [31:0] d_in
    );
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        a = a_in;
        b = b_in;
        c = c_in;
        d = d_in;
        a = a + b;
        d = d ^ a;
        d = {d[15:0], d[31:16]};
        c = c + d;
        b = b ^ c;
        b = {b[19:0], b[31:20]};
        a = a + b;
        d = d ^ a;
        d = {d[23:0], d[31:24]};
        c = c + d;
        b = b ^ c;
        b = {b[24:0], b[31:25]};
        return {d, c, b, a};
    endfunction

    // Assemble the 16-word initial state with word 0 in the low bits
    function automatic logic [511:0] build_state(
        input logic [255:0] k,
        input logic [95:0]  n,
        input logic [31:0]  ctr
    );
        return {n, ctr, k, SIGMA3, SIGMA2, SIGMA1, SIGMA0};
    endfunction

    state_t             state_q,   state_d;
    logic [511:0]       init_q,    init_d;
    logic [511:0]       work_q,    work_d;
    logic [4:0]         round_q,   round_d;
    logic [CNT_W-1:0]   remain_q,  remain_d;
    logic [511:0]       ks_data_q, ks_data_d;
    logic               done_q,    done_d;
    logic               wrap_q,    wrap_d;

    logic [3:0][127:0]  col_qr;
    logic [3:0][127:0]  diag_qr;
    logic [511:0]       col_state;
    logic [511:0]       diag_state;
    logic [511:0]       round_out;
    logic [511:0]       final_sum;
    logic [31:0]        cur_ctr;
    logic [31:0]        next_ctr;

    // Both round flavours are built in parallel. Quarter-round g touches one
    // word from each row: column g, or the diagonal starting at column g.
    for (genvar g = 0; g < 4; g++) begin : g_qr
        localparam int DB = 4 + ((g + 1) % 4);
        localparam int DC = 8 + ((g + 2) % 4);
        localparam int DD = 12 + ((g + 3) % 4);

        assign col_qr[g] = quarter(work_q[32*g +: 32],
                                   work_q[32*(4+g) +: 32],
                                   work_q[32*(8+g) +: 32],
                                   work_q[32*(12+g) +: 32]);

        assign col_state[32*g +: 32]      = col_qr[g][31:0];
        assign col_state[32*(4+g) +: 32]  = col_qr[g][63:32];
        assign col_state[32*(8+g) +: 32]  = col_qr[g][95:64];
        assign col_state[32*(12+g) +: 32] = col_qr[g][127:96];

        assign diag_qr[g] = quarter(work_q[32*g +: 32],
                                    work_q[32*DB +: 32],
                                    work_q[32*DC +: 32],
                                    work_q[32*DD +: 32]);

        assign diag_state[32*g +: 32]  = diag_qr[g][31:0];
        assign diag_state[32*DB +: 32] = diag_qr[g][63:32];
        assign diag_state[32*DC +: 32] = diag_qr[g][95:64];
        assign diag_state[32*DD +: 32] = diag_qr[g][127:96];
    end

    // Rounds alternate: counter even means an odd (column) round.
    assign round_out = round_q[0] ? diag_state : col_state;

    // Feed-forward addition of the initial state, word by word
    for (genvar g = 0; g < 16; g++) begin : g_sum
        assign final_sum[32*g +: 32] = work_q[32*g +: 32] + init_q[32*g +: 32];
    end

    assign cur_ctr  = init_q[415:384];
    assign next_ctr = cur_ctr + 32'd1;

    // Next-state logic: job acceptance, round iteration, result capture and
    // the output handshake with counter advance
    always_comb begin
        state_d   = state_q;
        init_d    = init_q;
        work_d    = work_q;
        round_d   = round_q;
        remain_d  = remain_q;
        ks_data_d = ks_data_q;
        done_d    = 1'b0;
        wrap_d    = wrap_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wrap_d = 1'b0;
                    if (num_blocks != '0) begin
                        init_d   = build_state(key, nonce, counter_init);
                        work_d   = build_state(key, nonce, counter_init);
                        round_d  = 5'd0;
                        remain_d = num_blocks;
                        state_d  = S_ROUND;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            S_ROUND: begin
                work_d  = round_out;
                round_d = round_q + 5'd1;
                if (round_q == LAST_ROUND) begin
                    state_d = S_FINAL;
                end
            end

            S_FINAL: begin
                ks_data_d = final_sum;
                state_d   = S_OUT;
            end

            S_OUT: begin
                if (ks_ready) begin
                    if (remain_q == CNT_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        remain_d = remain_q - CNT_W'(1);
                        init_d   = {init_q[511:416], next_ctr, init_q[383:0]};
                        work_d   = {init_q[511:416], next_ctr, init_q[383:0]};
                        round_d  = 5'd0;
                        state_d  = S_ROUND;
                        if (cur_ctr == 32'hFFFF_FFFF) begin
                            wrap_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any job and clears every output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            init_q    <= '0;
            work_q    <= '0;
            round_q   <= 5'd0;
            remain_q  <= '0;
            ks_data_q <= '0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            init_q    <= init_d;
            work_q    <= work_d;
            round_q   <= round_d;
            remain_q  <= remain_d;
            ks_data_q <= ks_data_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
        end
    end

    assign ks_data  = ks_data_q;
    assign ks_valid = (state_q == S_OUT);
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign ctr_wrap = wrap_q;

endmodule
